// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// opcodes, ALU codes, FSM states and datapath mux selects.
package riscv_mc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXECR     = 4'd7,
    S_EXECI     = 4'd8,
    S_ALUWB     = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_JALR_LINK = 4'd13,
    S_UPPER     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  function automatic logic [2:0] imm_fmt(
    input logic [6:0] op
  );
    logic [2:0] f;
    f = IMM_I;
    unique case (1'b1)
      op == OP_STORE:  f = IMM_S;
      op == OP_BRANCH: f = IMM_B;
      op == OP_JAL:    f = IMM_J;
      (op == OP_LUI) || (op == OP_AUIPC):
        f = IMM_U;
      default:         f = IMM_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation select from aluop class and funct fields.
// Purely combinational.
module mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       rtype,
  input  logic [1:0] aluop,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_BRANCH: begin
        unique case (funct3[2:1])
          2'b10:   alucontrol = ALU_SLT;
          2'b11:   alucontrol = ALU_SLTU;
          default: alucontrol = ALU_SUB;
        endcase
      end
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000: alucontrol = (rtype && funct7b5)
                             ? ALU_SUB : ALU_ADD;
          3'b001: alucontrol = ALU_SLL;
          3'b010: alucontrol = ALU_SLT;
          3'b011: alucontrol = ALU_SLTU;
          3'b100: alucontrol = ALU_XOR;
          3'b101: alucontrol = funct7b5
                             ? ALU_SRA : ALU_SRL;
          3'b110: alucontrol = ALU_OR;
          3'b111: alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: one FSM sequencing
// fetch/decode/execute/memory/writeback over a shared ALU.
module multicycle_control_unit
  import riscv_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  state_t     state, next;
  logic       rdy;
  logic       rtype;
  logic [1:0] aluop;
  logic [3:0] alu_code;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  mc_alu_decoder u_aludec (
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .rtype      (rtype),
    .aluop      (aluop),
    .alucontrol (alu_code)
  );

  always_comb begin
    next      = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    rtype     = 1'b0;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = rdy;
        PCWrite   = rdy;
        if (rdy) next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          (op == OP_LOAD) || (op == OP_STORE):
            next = S_MEMADR;
          op == OP_R:      next = S_EXECR;
          op == OP_I:      next = S_EXECI;
          op == OP_BRANCH: next = S_BRANCH;
          op == OP_JAL:    next = S_JAL;
          op == OP_JALR:   next = S_JALR;
          (op == OP_LUI) || (op == OP_AUIPC):
            next = S_UPPER;
          default:         next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        next = (op == OP_LOAD)
             ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (rdy) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (rdy) next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
        rtype   = 1'b1;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_BRANCH;
        // funct3 01x has no branch encoding
        if (funct3[2:1] == 2'b01) begin
          next = S_TRAP;
        end else begin
          PCWrite = Zero ^ funct3[0] ^ funct3[2];
          next    = S_FETCH;
        end
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        next    = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        if (funct3 != 3'b000) begin
          next = S_TRAP;
        end else begin
          PCWrite = 1'b1;
          next    = S_JALR_LINK;
        end
      end
      S_JALR_LINK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        next    = S_ALUWB;
      end
      S_UPPER: begin
        ALUSrcA = (op == OP_LUI)
                ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        next    = S_ALUWB;
      end
      S_TRAP: next = S_TRAP;
    endcase
  end

  // ImmSrc follows op in every state but must read 0 in reset
  assign ImmSrc     = rst_n ? imm_fmt(op) : IMM_I;
  assign ALUControl = ALUCTRL_W'(alu_code);
  assign illegal    = (state == S_TRAP);
  assign state_o    = state;

endmodule
